pool_engine: RTL and testbench

Parametrised pooling stage between the requantisation units and the output buffer. It collects int8 samples from SA_N systolic-array columns into a per-tile scratch array and emits one pooled int8 result per complete FILTER_H×FILTER_W block, in max or average mode. Results leave through a ready/valid output FIFO, with input backpressure and an explicit tile start/done protocol.

---
 rtl/pool_pkg.sv | 38 +++
 rtl/pool_out_fifo.sv | 76 +++++++
 rtl/pool_engine.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_pool_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared types for the pooling stage: the int8 sample type, pooling mode and
// FSM state enums, and the result record carried through the output FIFO.
// Ports: none (package).
// -----------------------------------------------------------------------------
package pool_pkg;

    // Project-wide signed 8-bit sample type.
    typedef logic signed [7:0] int8_t;

    // Coordinate width of a stored result; matches $clog2(512+1) for the
    // default feature-map bound.
    localparam int POOL_COORD_W = 10;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } pool_state_e;

    typedef struct packed {
        logic [POOL_COORD_W-1:0] row;
        logic [POOL_COORD_W-1:0] col;
        int8_t                   data;
    } pool_result_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_out_fifo.sv
// -----------------------------------------------------------------------------
// pool_out_fifo
// First-word-fall-through result FIFO. The head entry is visible on head_o
// whenever valid_o is high; pop_i consumes it. A push is refused while full
// (the producer is expected to qualify on count_o anyway).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push_i/push_data_i  write request and payload
//   pop_i             consume head entry
//   valid_o/head_o    head valid and payload (payload reads 0 when empty)
//   count_o           current occupancy
// -----------------------------------------------------------------------------
module pool_out_fifo
    import pool_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = idx_width(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  pool_result_t       push_data_i,
    input  logic               pop_i,
    output logic               valid_o,
    output pool_result_t       head_o,
    output logic [CNT_W-1:0]   count_o
);

    pool_result_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign do_push = push_i && (count_q < CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    // Gate the head so outputs read zero when nothing is queued.
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/pool_engine.sv
// -----------------------------------------------------------------------------
// pool_engine
// Collects int8 samples from SA_N lanes into an SA_N x SA_N scratch tile and
// emits one pooled value (max or rounded average) per complete
// FILTER_H x FILTER_W block through a ready/valid FIFO.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   tile_start, mode, pos_row/col  tile launch (sampled only when idle)
//   in_valid/in_row/in_col/in_data per-lane sample input, in_ready shared accept
//   out_valid/out_ready/out_row/out_col/out_data  pooled result stream
//   busy, tile_done                status; tile_done is a one-cycle pulse
//   err_oob, err_ovw               sticky out-of-tile / overwrite flags
// -----------------------------------------------------------------------------
module pool_engine
    import pool_pkg::*;
#(
    parameter int SA_N      = 4,
    parameter int MAX_N     = 512,
    parameter int N_BITS    = $clog2(MAX_N + 1),
    parameter int FILTER_H  = 2,
    parameter int FILTER_W  = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tile_start,
    input  logic              mode,
    input  logic [N_BITS-1:0] pos_row,
    input  logic [N_BITS-1:0] pos_col,
    input  logic [SA_N-1:0]   in_valid,
    input  logic [N_BITS-1:0] in_row [SA_N],
    input  logic [N_BITS-1:0] in_col [SA_N],
    input  int8_t             in_data [SA_N],
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out_row,
    output logic [N_BITS-1:0] out_col,
    output int8_t             out_data,
    output logic              busy,
    output logic              tile_done,
    output logic              err_oob,
    output logic              err_ovw
);

    localparam int NCELL  = SA_N * SA_N;
    localparam int CELL_W = idx_width(NCELL);
    localparam int HW     = FILTER_H * FILTER_W;
    localparam int LOG_HW = $clog2(HW);
    localparam int SUM_W  = 8 + LOG_HW;
    localparam int NBC    = SA_N / FILTER_W;
    localparam int NB     = (SA_N / FILTER_H) * NBC;
    localparam int BLK_W  = idx_width(NB);
    localparam int BCNT_W = $clog2(NB + 1);
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);

    // Control state
    pool_state_e         state_q;
    pool_mode_e          mode_q;
    logic [N_BITS-1:0]   pos_row_q;
    logic [N_BITS-1:0]   pos_col_q;
    logic [BCNT_W-1:0]   blk_cnt_q;
    logic                tile_done_q;
    logic                err_oob_q;
    logic                err_ovw_q;

    // Scratch tile
    logic [NCELL-1:0]    valid_map_q;
    logic [NCELL-1:0]    valid_map_d;
    int8_t               cell_data_q [NCELL];

    // Write decode
    logic [N_BITS-1:0]   dr [SA_N];
    logic [N_BITS-1:0]   dc [SA_N];
    logic [SA_N-1:0]     lane_in_tile;
    logic [CELL_W-1:0]   lane_cell [SA_N];
    logic [NCELL-1:0]    wr_en;
    int8_t               wr_data [NCELL];
    logic                oob_hit;
    logic                ovw_hit;

    // Block scan / reduction
    logic [NB*HW-1:0]    blk_valid_flat;
    int8_t               blk_vals [NB*HW];
    logic [NB-1:0]       blk_full;
    logic [N_BITS-1:0]   blk_row_off [NB];
    logic [N_BITS-1:0]   blk_col_off [NB];
    logic                found;
    logic [BLK_W-1:0]    sel_blk;
    int                  sel_base;
    int8_t               max_v;
    logic signed [SUM_W-1:0] sum_v;
    logic signed [SUM_W-1:0] avg_full;
    int8_t               pool_val;
    logic [NCELL-1:0]    cell_clr;

    // FIFO interface
    logic                push;
    pool_result_t        push_res;
    logic                fifo_valid;
    pool_result_t        fifo_head;
    logic [CNT_W-1:0]    fifo_count;
    logic                pop;

    assign in_ready = (state_q == ACTIVE) && (fifo_count < CNT_W'(OUT_DEPTH));
    assign pop      = fifo_valid && out_ready;

    // -------------------------------------------------------------------------
    // Per-lane offset into the tile. The subtraction wraps at N_BITS, so a
    // sample below the base becomes a large offset and is rejected as OOB.
    // -------------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < SA_N; gi++) begin : g_lane
            assign dr[gi] = in_row[gi] - pos_row_q;
            assign dc[gi] = in_col[gi] - pos_col_q;
            assign lane_in_tile[gi] = (dr[gi] < N_BITS'(SA_N)) && (dc[gi] < N_BITS'(SA_N));
            assign lane_cell[gi] = CELL_W'(dr[gi]) * CELL_W'(SA_N) + CELL_W'(dc[gi]);
        end
    endgenerate

    // Higher-numbered lanes win if two lanes target the same cell.
    always_comb begin
        wr_en   = '0;
        oob_hit = 1'b0;
        ovw_hit = 1'b0;
        for (int c = 0; c < NCELL; c++) begin
            wr_data[c] = cell_data_q[c];
        end
        for (int i = 0; i < SA_N; i++) begin
            if (in_valid[i] && in_ready) begin
                if (lane_in_tile[i]) begin
                    wr_en[lane_cell[i]]   = 1'b1;
                    wr_data[lane_cell[i]] = in_data[i];
                    if (valid_map_q[lane_cell[i]]) begin
                        ovw_hit = 1'b1;
                    end
                end else begin
                    oob_hit = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Block geometry: gather each block's valid bits and samples. Block index
    // is row-major over the tile, so the lowest full index is the scan winner.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NB; gi++) begin : g_blk
            localparam int BR = gi / NBC;
            localparam int BC = gi % NBC;
            for (gj = 0; gj < HW; gj++) begin : g_cell
                localparam int CELL = (BR * FILTER_H + gj / FILTER_W) * SA_N
                                      + BC * FILTER_W + gj % FILTER_W;
                assign blk_valid_flat[gi*HW + gj] = valid_map_q[CELL];
                assign blk_vals[gi*HW + gj]       = cell_data_q[CELL];
            end
            assign blk_full[gi]    = &blk_valid_flat[gi*HW +: HW];
            assign blk_row_off[gi] = N_BITS'(BR * FILTER_H);
            assign blk_col_off[gi] = N_BITS'(BC * FILTER_W);
        end
    endgenerate

    always_comb begin
        found   = 1'b0;
        sel_blk = '0;
        for (int b = NB - 1; b >= 0; b--) begin
            if (blk_full[b]) begin
                found   = 1'b1;
                sel_blk = BLK_W'(b);
            end
        end
    end

    // Reduction over the selected block. The average adds half the window
    // before the arithmetic shift, giving round-half-up on the signed sum.
    always_comb begin
        sel_base = int'(sel_blk) * HW;
        max_v    = blk_vals[sel_base];
        sum_v    = '0;
        for (int k = 0; k < HW; k++) begin
            if (blk_vals[sel_base + k] > max_v) begin
                max_v = blk_vals[sel_base + k];
            end
            sum_v = sum_v + SUM_W'(blk_vals[sel_base + k]);
        end
        avg_full = (sum_v + SUM_W'(HW / 2)) >>> LOG_HW;
        pool_val = (mode_q == POOL_AVG) ? int8_t'(avg_full[7:0]) : max_v;
    end

    // Push only on occupancy sampled at cycle start; a same-cycle pop does
    // not make room for this cycle's push.
    assign push = (state_q == ACTIVE) && found && (fifo_count < CNT_W'(OUT_DEPTH));

    always_comb begin
        push_res.row  = POOL_COORD_W'(pos_row_q + blk_row_off[sel_blk]);
        push_res.col  = POOL_COORD_W'(pos_col_q + blk_col_off[sel_blk]);
        push_res.data = pool_val;
    end

    generate
        for (gi = 0; gi < NCELL; gi++) begin : g_clr
            localparam int CB = ((gi / SA_N) / FILTER_H) * NBC + (gi % SA_N) / FILTER_W;
            assign cell_clr[gi] = push && (sel_blk == BLK_W'(CB));
        end
    endgenerate

    // A write landing on a cell being cleared this cycle keeps it valid.
    always_comb begin
        if ((state_q == IDLE) && tile_start) begin
            valid_map_d = '0;
        end else begin
            valid_map_d = (valid_map_q & ~cell_clr) | wr_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_map_q <= '0;
        end else begin
            valid_map_q <= valid_map_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCELL; c++) begin
            if (wr_en[c]) begin
                cell_data_q[c] <= wr_data[c];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tile FSM with registered status outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= POOL_MAX;
            pos_row_q   <= '0;
            pos_col_q   <= '0;
            blk_cnt_q   <= '0;
            tile_done_q <= 1'b0;
            err_oob_q   <= 1'b0;
            err_ovw_q   <= 1'b0;
        end else begin
            tile_done_q <= 1'b0;
            if (oob_hit) begin
                err_oob_q <= 1'b1;
            end
            if (ovw_hit) begin
                err_ovw_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (tile_start) begin
                        mode_q    <= pool_mode_e'(mode);
                        pos_row_q <= pos_row;
                        pos_col_q <= pos_col;
                        blk_cnt_q <= '0;
                        state_q   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (push) begin
                        blk_cnt_q <= blk_cnt_q + BCNT_W'(1);
                        if (blk_cnt_q == BCNT_W'(NB - 1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_count == '0) begin
                        state_q     <= IDLE;
                        tile_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    pool_out_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_res),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign out_valid = fifo_valid;
    assign out_row   = N_BITS'(fifo_head.row);
    assign out_col   = N_BITS'(fifo_head.col);
    assign out_data  = fifo_head.data;
    assign busy      = (state_q != IDLE);
    assign tile_done = tile_done_q;
    assign err_oob   = err_oob_q;
    assign err_ovw   = err_ovw_q;

endmodule

// File: tb/tb_pool_engine.sv
// -----------------------------------------------------------------------------
// tb_pool_engine
// Scoreboard bench for pool_engine: expected results are queued as blocks are
// completed by the stimulus and compared as the DUT hands them out.
// -----------------------------------------------------------------------------
module tb_pool_engine;
    import pool_pkg::*;

    localparam int SA_N   = 4;
    localparam int N_BITS = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              tile_start;
    logic              mode;
    logic [N_BITS-1:0] pos_row;
    logic [N_BITS-1:0] pos_col;
    logic [SA_N-1:0]   in_valid;
    logic [N_BITS-1:0] in_row [SA_N];
    logic [N_BITS-1:0] in_col [SA_N];
    int8_t             in_data [SA_N];
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] out_row;
    logic [N_BITS-1:0] out_col;
    int8_t             out_data;
    logic              busy;
    logic              tile_done;
    logic              err_oob;
    logic              err_ovw;

    always #5 clk = ~clk;

    pool_engine #(
        .SA_N      (SA_N),
        .MAX_N     (512),
        .N_BITS    (N_BITS),
        .FILTER_H  (2),
        .FILTER_W  (2),
        .OUT_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tile_start (tile_start),
        .mode       (mode),
        .pos_row    (pos_row),
        .pos_col    (pos_col),
        .in_valid   (in_valid),
        .in_row     (in_row),
        .in_col     (in_col),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_data   (out_data),
        .busy       (busy),
        .tile_done  (tile_done),
        .err_oob    (err_oob),
        .err_ovw    (err_ovw)
    );

    typedef struct {
        int row;
        int col;
        int data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference pooling of one 2x2 window.
    function automatic int pool_model(input bit avg, input int v[4]);
        int m = v[0];
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            if (v[k] > m) m = v[k];
            s += v[k];
        end
        if (avg) return (s + 2) >>> 2;
        return m;
    endfunction

    task automatic push_exp(input int r, input int c, input int d);
        exp_t e;
        e.row = r;
        e.col = c;
        e.data = d;
        sb.push_back(e);
    endtask

    // Output monitor: compare each handshake against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            check_eq("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                $display("pop row=%0d col=%0d data=%0d (exp %0d,%0d,%0d)",
                         out_row, out_col, out_data, e.row, e.col, e.data);
                check_eq("out_row", out_row, e.row);
                check_eq("out_col", out_col, e.col);
                check_eq("out_data", out_data, e.data);
            end
        end
    end

    // Drive n lanes for one accepted beat; called #1 after a rising edge.
    task automatic send(input int n, input int rr[4], input int cc[4], input int dd[4]);
        int budget = 0;
        for (int i = 0; i < SA_N; i++) begin
            in_valid[i] = (i < n);
            in_row[i]   = N_BITS'(rr[i]);
            in_col[i]   = N_BITS'(cc[i]);
            in_data[i]  = int8_t'(dd[i]);
        end
        while (!in_ready && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 200) check_eq("in_ready_wait", in_ready, 1);
        $display("send lanes=%0d r0=%0d c0=%0d d0=%0d", n, rr[0], cc[0], dd[0]);
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    task automatic send_block(input int pr, input int pc, input int br, input int bc,
                              input int v[4]);
        int r0 = pr + br * 2;
        int c0 = pc + bc * 2;
        send(2, '{r0, r0, 0, 0}, '{c0, c0 + 1, 0, 0}, '{v[0], v[1], 0, 0});
        send(2, '{r0 + 1, r0 + 1, 0, 0}, '{c0, c0 + 1, 0, 0}, '{v[2], v[3], 0, 0});
    endtask

    task automatic start_tile(input bit avg, input int pr, input int pc);
        tile_start = 1'b1;
        mode       = avg;
        pos_row    = N_BITS'(pr);
        pos_col    = N_BITS'(pc);
        @(posedge clk);
        #1;
        tile_start = 1'b0;
        $display("tile_start mode=%0d pos=(%0d,%0d)", avg, pr, pc);
    endtask

    task automatic wait_tile_done(input int budget);
        int k = 0;
        while (!tile_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("tile_done_seen", tile_done, 1);
    endtask

    function automatic void rand_vals(output int v[4]);
        for (int k = 0; k < 4; k++) v[k] = int'($urandom_range(0, 255)) - 128;
    endfunction

    initial begin
        int v[4];
        int t[4][4];
        int np;
        int k;

        reset      = 1'b1;
        tile_start = 1'b0;
        mode       = 1'b0;
        pos_row    = '0;
        pos_col    = '0;
        in_valid   = '0;
        out_ready  = 1'b0;
        for (int i = 0; i < SA_N; i++) begin
            in_row[i]  = '0;
            in_col[i]  = '0;
            in_data[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tile_done", tile_done, 0);
        check_eq("rst_err_oob", err_oob, 0);
        check_eq("rst_err_ovw", err_ovw, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_row", out_row, 0);

        // MAX tile at (8,4) with latency check on the first block
        out_ready = 1'b1;
        start_tile(1'b0, 8, 4);
        check_eq("a_busy", busy, 1);
        check_eq("a_in_ready", in_ready, 1);
        send_block(8, 4, 0, 0, '{-3, 7, 2, -128});
        push_exp(8, 4, 7);
        check_eq("a_lat_k", out_valid, 0);
        @(posedge clk);
        #1;
        check_eq("a_lat_k1", out_valid, 1);
        check_eq("a_max_data", out_data, 7);
        check_eq("a_max_row", out_row, 8);
        check_eq("a_max_col", out_col, 4);
        for (int b = 1; b < 4; b++) begin
            rand_vals(v);
            send_block(8, 4, b / 2, b % 2, v);
            push_exp(8 + (b / 2) * 2, 4 + (b % 2) * 2, pool_model(1'b0, v));
        end
        wait_tile_done(60);
        @(negedge clk);
        check_eq("a_done_pulse", tile_done, 0);
        check_eq("a_idle", busy, 0);

        // AVG tile at (0,0) with rounding vectors
        @(posedge clk);
        #1;
        start_tile(1'b1, 0, 0);
        send_block(0, 0, 0, 0, '{1, 2, 2, 2});
        push_exp(0, 0, 2);
        send_block(0, 0, 0, 1, '{-1, -2, -2, -2});
        push_exp(0, 2, -2);
        for (int b = 2; b < 4; b++) begin
            rand_vals(v);
            send_block(0, 0, b / 2, b % 2, v);
            push_exp((b / 2) * 2, (b % 2) * 2, pool_model(1'b1, v));
        end
        wait_tile_done(60);
        @(posedge clk);
        #1;

        // Full tile streamed by rows with the consumer stalled
        out_ready = 1'b0;
        start_tile(1'b1, 16, 32);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) t[r][c] = int'($urandom_range(0, 255)) - 128;
            send(4, '{16 + r, 16 + r, 16 + r, 16 + r}, '{32, 33, 34, 35},
                 '{t[r][0], t[r][1], t[r][2], t[r][3]});
            if (r % 2 == 1) begin
                for (int bc = 0; bc < 2; bc++) begin
                    v = '{t[r-1][2*bc], t[r-1][2*bc+1], t[r][2*bc], t[r][2*bc+1]};
                    push_exp(16 + r - 1, 32 + 2 * bc, pool_model(1'b1, v));
                end
            end
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("c_full_in_ready", in_ready, 0);
        check_eq("c_full_out_valid", out_valid, 1);
        check_eq("c_full_busy", busy, 1);
        check_eq("c_hold_row", out_row, sb[0].row);
        check_eq("c_hold_data", out_data, sb[0].data);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("c_hold2_col", out_col, sb[0].col);
        check_eq("c_hold2_data", out_data, sb[0].data);
        out_ready = 1'b1;
        np = 0;
        k  = 0;
        while (np < 4 && k < 50) begin
            @(negedge clk);
            if (out_valid && out_ready) np++;
            k++;
        end
        check_eq("c_pop_count", np, 4);
        @(negedge clk);
        check_eq("c_empty", out_valid, 0);
        check_eq("c_done_early", tile_done, 0);
        @(negedge clk);
        check_eq("c_done", tile_done, 1);
        @(negedge clk);
        check_eq("c_done_pulse", tile_done, 0);

        // Out-of-tile drop and overwrite flags, then reset with results queued
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        start_tile(1'b0, 0, 0);
        send(1, '{4, 0, 0, 0}, '{0, 0, 0, 0}, '{55, 0, 0, 0});
        check_eq("d_err_oob", err_oob, 1);
        check_eq("d_err_ovw_clear", err_ovw, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("d_oob_no_out", out_valid, 0);
        send(1, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{5, 0, 0, 0});
        check_eq("d_no_ovw_yet", err_ovw, 0);
        send(1, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{9, 0, 0, 0});
        check_eq("d_err_ovw", err_ovw, 1);
        check_eq("d_oob_sticky", err_oob, 1);
        send(3, '{0, 1, 1, 0}, '{1, 0, 1, 0}, '{1, 2, 3, 0});
        rand_vals(v);
        send_block(0, 0, 0, 1, v);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("d_queued_valid", out_valid, 1);
        check_eq("d_overwrite_data", out_data, 9);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_eq("r_out_valid", out_valid, 0);
        check_eq("r_busy", busy, 0);
        check_eq("r_in_ready", in_ready, 0);
        check_eq("r_err_oob", err_oob, 0);
        check_eq("r_err_ovw", err_ovw, 0);
        check_eq("r_out_data", out_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // New tile after reset: AVG boundary vectors
        out_ready = 1'b1;
        start_tile(1'b1, 4, 8);
        send_block(4, 8, 1, 1, '{100, 100, 100, 101});
        push_exp(6, 10, 100);
        send_block(4, 8, 0, 0, '{-128, -128, -128, -128});
        push_exp(4, 8, -128);
        k = 0;
        while (sb.size() > 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("e_sb_drained", sb.size(), 0);
        check_eq("e_busy", busy, 1);
        check_eq("e_err_oob", err_oob, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
